// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU result path.
//   - ST_ZERO/ST_NEG/ST_ONES/ST_ERR : bit positions inside a status word
//   - status_t                      : 4-bit status word {ERR, ONES, NEG, ZERO}
//   - ERR_CNT_W                     : width of the saturating error counter
package alu_pkg;

  localparam int ST_ZERO = 0;
  localparam int ST_NEG  = 1;
  localparam int ST_ONES = 2;
  localparam int ST_ERR  = 3;

  typedef logic [3:0] status_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/bufor_wyniku_kolejka.sv
// kolejka_wynikow
//   Generic synchronous FIFO built as a circular buffer.
//   Ports:
//     clk, rst (async, active-high)
//     push, wr_data : write request; ignored while full
//     pop           : read request; ignored while empty
//     rd_data       : entry at the read pointer (combinational read)
//     full, empty   : derived from the registered count only
//   Handshake: the enclosing stage treats push as "valid && ready" and
//   pop as "valid && ready" on the output side; full/empty never depend
//   combinationally on push or pop.
module kolejka_wynikow #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  logic do_push;
  logic do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end

  // Storage carries no reset; stale contents are hidden by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bufor_wyniku.sv
// bufor_wyniku
//   Result stage behind the ALU operation units. Captures the selected
//   result and error flag, forces errored results to zero, derives status
//   flags {ERR, ONES, NEG, ZERO} and queues entries in order.
//   Ports:
//     i_clk, i_rst       : clock, async active-high reset
//     i_result, i_error  : operation unit output
//     i_valid / o_ready  : input handshake, push = i_valid && o_ready
//     o_result, o_status : head entry (zero while empty)
//     o_valid / i_ready  : output handshake, pop = o_valid && i_ready
//     o_err_cnt          : saturating count of accepted errored pushes,
//                          present only when BUFOR_ERR_CNT_EN is defined
//   o_ready and o_valid come from registered queue state only.
module bufor_wyniku
  import alu_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BITS-1:0]      i_result,
  input  logic                 i_error,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [BITS-1:0]      o_result,
  output logic [3:0]           o_status,
  output logic                 o_valid,
`ifdef BUFOR_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] o_err_cnt,
`endif
  input  logic                 i_ready
);

  localparam int W = BITS + 4;

  logic [BITS-1:0] stored;
  status_t         st;
  logic [W-1:0]    wr_data;
  logic [W-1:0]    rd_data;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Upstream result is undefined on error; replace it with zero.
  assign stored = i_error ? '0 : i_result;

  always_comb begin
    st          = '0;
    st[ST_ERR]  = i_error;
    st[ST_ZERO] = !i_error && (stored == '0);
    st[ST_NEG]  = !i_error && stored[BITS-1];
    st[ST_ONES] = !i_error && (stored == '1);
  end

  assign wr_data = {st, stored};
  assign push    = i_valid && !full;
  assign pop     = !empty && i_ready;

  kolejka_wynikow #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_kolejka (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  assign o_ready  = !full;
  assign o_valid  = !empty;
  assign o_result = empty ? '0 : rd_data[BITS-1:0];
  assign o_status = empty ? '0 : rd_data[W-1:BITS];

`ifdef BUFOR_ERR_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_cnt <= '0;
    end else if (push && i_error && (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bufor_wyniku.sv
module tb_bufor_wyniku;
  localparam int BITS  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [BITS-1:0] i_result = '0;
  logic            i_error = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready = 1'b0;
  logic            o_ready;
  logic [BITS-1:0] o_result;
  logic [3:0]      o_status;
  logic            o_valid;
`ifdef BUFOR_ERR_CNT_EN
  logic [7:0]      o_err_cnt;
  int              exp_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: queue of {status, result} entries.
  logic [BITS+3:0] exp_q[$];

  bufor_wyniku #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_result (i_result),
    .i_error  (i_error),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_result (o_result),
    .o_status (o_status),
    .o_valid  (o_valid),
`ifdef BUFOR_ERR_CNT_EN
    .o_err_cnt(o_err_cnt),
`endif
    .i_ready  (i_ready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [3:0] flags(input logic err, input logic [BITS-1:0] v);
    if (err) return 4'b1000;
    return {1'b0, (v == {BITS{1'b1}}), v[BITS-1], (v == '0)};
  endfunction

  task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
`ifdef BUFOR_ERR_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
      bit do_push, do_pop;
      do_push = i_valid && (exp_q.size() < DEPTH);
      do_pop  = (exp_q.size() != 0) && i_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        logic [BITS-1:0] v;
        v = i_error ? '0 : i_result;
        exp_q.push_back({flags(i_error, v), v});
`ifdef BUFOR_ERR_CNT_EN
        if (i_error && exp_cnt < 255) exp_cnt++;
`endif
      end
    end
  end

  // Scoreboard compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", BITS'(o_valid), BITS'(exp_q.size() != 0));
      check("ready", BITS'(o_ready), BITS'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0) begin
        check("result", o_result, exp_q[0][BITS-1:0]);
        check("status", BITS'(o_status), BITS'(exp_q[0][BITS+3:BITS]));
      end else begin
        check("result_empty", o_result, '0);
        check("status_empty", BITS'(o_status), '0);
      end
`ifdef BUFOR_ERR_CNT_EN
      check("err_cnt", BITS'(o_err_cnt), BITS'(exp_cnt));
`endif
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input logic [BITS-1:0] r, input logic rd);
    i_valid  = v;
    i_error  = e;
    i_result = r;
    i_ready  = rd;
  endtask

  logic [3:0] drain_st [4];

  initial begin
    drain_st[0] = 4'b0001;
    drain_st[1] = 4'b0010;
    drain_st[2] = 4'b0110;
    drain_st[3] = 4'b0000;

    // Reset
    #12;
    rst = 1'b0;
    #1;
    check("rst_valid", BITS'(o_valid), 0);
    check("rst_ready", BITS'(o_ready), 1);
    check("rst_result", o_result, 0);
    step();

    // Single entry, latency one edge
    drive(1, 0, 32'h0000_0005, 1);
    step();
    drive(0, 0, 0, 1);
    @(negedge clk);
    check("t1_valid", BITS'(o_valid), 1);
    check("t1_result", o_result, 32'h5);
    check("t1_status", BITS'(o_status), 0);
    step();
    @(negedge clk);
    check("t1_popped", BITS'(o_valid), 0);
    step();

    // Fill to full, fifth dropped, drain in order
    drive(1, 0, 32'h0, 0);          step();
    drive(1, 0, 32'h8000_0000, 0);  step();
    drive(1, 0, 32'hFFFF_FFFF, 0);  step();
    drive(1, 0, 32'h7, 0);          step();
    check("t2_full", BITS'(o_ready), 0);
    drive(1, 0, 32'h99, 0);         step();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_drain", BITS'(o_status), BITS'(drain_st[i]));
      step();
    end
    @(negedge clk);
    check("t2_dropped", BITS'(o_valid), 0);
    step();

    // Errored push with undefined result
    drive(1, 1, 'x, 1);
    step();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t3_result", o_result, 0);
    check("t3_status", BITS'(o_status), BITS'(4'b1000));
`ifdef BUFOR_ERR_CNT_EN
    check("t3_cnt", BITS'(o_err_cnt), 1);
`endif
    drive(0, 0, 0, 1);
    step();
    step();

    // Streaming push and pop every cycle
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, BITS'(100 + i), 1);
      step();
    end
    drive(0, 0, 0, 1);
    @(negedge clk);
    check("t4_last", o_result, 32'd119);
    step();
    step();

    // Asynchronous reset between edges
    drive(1, 0, 32'hAAAA, 0); step();
    drive(1, 0, 32'hBBBB, 0); step();
    drive(1, 0, 32'hCCCC, 0); step();
    drive(0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_valid", BITS'(o_valid), 0);
    check("t5_ready", BITS'(o_ready), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_old", BITS'(o_valid), 0);
    step();

`ifdef BUFOR_ERR_CNT_EN
    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, BITS'($urandom), 1);
      step();
    end
    drive(0, 0, 0, 1);
    @(negedge clk);
    check("t6_sat", BITS'(o_err_cnt), 255);
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [BITS-1:0] r;
      case ($urandom_range(0, 4))
        0: r = '0;
        1: r = '1;
        2: r = {1'b1, BITS'($urandom) >> 1};
        default: r = BITS'($urandom);
      endcase
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), r,
            1'($urandom_range(0, 2) != 0));
      step();
    end
    drive(0, 0, 0, 1);
    repeat (DEPTH + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
